writeback_arbiter: RTL

//  Writeback stage directly upstream of the register file: merges in-order ALU results and

---
 rtl/writeback_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges in-order ALU results with FIFO-buffered mult/div results
// onto the single registered regfile write port, and exports a pending-register mask.
module writeback_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clock,
    input  logic                       ctrl_reset_n,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       md_valid,
    input  logic [ADDR_W-1:0]          md_rd,
    input  logic [DATA_W-1:0]          md_data,
    output logic                       md_ready,
    output logic                       ctrl_writeEnable,
    output logic [ADDR_W-1:0]          ctrl_writeReg,
    output logic [DATA_W-1:0]          data_writeReg,
    output logic [31:0]                pending_mask,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] fifo_rd_q;
    logic [DEPTH-1:0][DATA_W-1:0] fifo_data_q;
    logic [DEPTH-1:0]             ent_vld_q, ent_vld_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;

    logic                         we_q, we_d;
    logic [ADDR_W-1:0]            wreg_q, wreg_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic                         out_md_q, out_md_d;

    logic                         alu_sel;
    logic                         push;
    logic                         pop;

    // Ready looks only at registered occupancy so it never forms a path from md_valid.
    assign md_ready = ctrl_reset_n && (count_q < CNT_W'(DEPTH));

    assign alu_sel = alu_valid && (alu_rd != '0);
    assign push    = md_valid && md_ready && (md_rd != '0);
    assign pop     = !alu_sel && (count_q != '0);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ent_vld_d = ent_vld_q;
        if (push) begin
            wr_ptr_d            = wr_ptr_q + 1'b1;
            ent_vld_d[wr_ptr_q] = 1'b1;
        end
        if (pop) begin
            rd_ptr_d            = rd_ptr_q + 1'b1;
            ent_vld_d[rd_ptr_q] = 1'b0;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        out_md_d = 1'b0;
        if (alu_sel) begin
            we_d    = 1'b1;
            wreg_d  = alu_rd;
            wdata_d = alu_data;
        end else if (pop) begin
            we_d     = 1'b1;
            wreg_d   = fifo_rd_q[rd_ptr_q];
            wdata_d  = fifo_data_q[rd_ptr_q];
            out_md_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ent_vld_q <= '0;
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            out_md_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ent_vld_q <= ent_vld_d;
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            out_md_q  <= out_md_d;
        end
    end

    // Payload storage needs no reset; ent_vld_q qualifies every use of it.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= md_rd;
            fifo_data_q[wr_ptr_q] <= md_data;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i]) pending_mask = pending_mask | (32'd1 << fifo_rd_q[i]);
        end
        if (out_md_q && we_q) pending_mask = pending_mask | (32'd1 << wreg_q);
        pending_mask[0] = 1'b0;
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign fifo_count       = count_q;

endmodule
